// File: rtl/sbox_share_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sbox_share_sequencer_pkg
// Brief    : Shared types and constants for the masked S-box share sequencer.
// Revision : 1.0
// ============================================================================
package sbox_share_sequencer_pkg;

    localparam int          c_LFSR_W    = 16;
    // Feedback from bits 15,13,12,10: x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;
    localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
    localparam int          c_SHARE_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_OUT     = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sbox_fresh_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : sbox_fresh_lfsr
// Brief    : Free-running 16-bit Fibonacci LFSR supplying masks and fresh bits.
// Revision : 1.0
// ============================================================================
module sbox_fresh_lfsr
    import sbox_share_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                seed_load_i,
    input  logic [c_LFSR_W-1:0] seed_val_i,
    output logic [7:0]          fresh_o
);

    logic [c_LFSR_W-1:0] lfsr_q;
    logic [c_LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[c_LFSR_W-2:0], ^(lfsr_q & c_LFSR_TAPS)};
        // An all-zero state would lock the register, so substitute the default seed
        if (seed_load_i) begin
            lfsr_d = (seed_val_i == '0) ? c_LFSR_SEED : seed_val_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= c_LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign fresh_o = lfsr_q[7:0];

endmodule
`default_nettype wire

// File: rtl/sbox_share_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sbox_share_sequencer
// Brief    : Splits a nibble into two shares, drives a masked S-box, recombines.
// Revision : 1.0
// ============================================================================
module sbox_share_sequencer
    import sbox_share_sequencer_pkg::*;
#(
    parameter int LATENCY = 5,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [c_SHARE_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [c_SHARE_W-1:0] out_data,
    input  logic                 seed_load,
    input  logic [c_LFSR_W-1:0]  seed_val,
    output logic [c_SHARE_W-1:0] X_s0,
    output logic [c_SHARE_W-1:0] X_s1,
    output logic [c_SHARE_W-1:0] Fresh,
    output logic                 sbox_rst,
    input  logic                 Synch,
    input  logic [c_SHARE_W-1:0] Y_s0,
    input  logic [c_SHARE_W-1:0] Y_s1,
    output logic                 err
);

    // Counter must cover both the timeout and the programmed S-box latency
    localparam int c_CNT_MAX = (TIMEOUT > LATENCY) ? TIMEOUT : LATENCY;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    state_t               state_q, state_d;
    logic [c_SHARE_W-1:0] xs0_q, xs0_d;
    logic [c_SHARE_W-1:0] xs1_q, xs1_d;
    logic [c_SHARE_W-1:0] fresh_q, fresh_d;
    logic [c_SHARE_W-1:0] out_q, out_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]           w_rand;

    sbox_fresh_lfsr u_lfsr (
        .clk         (clk),
        .rst         (rst),
        .seed_load_i (seed_load),
        .seed_val_i  (seed_val),
        .fresh_o     (w_rand)
    );

    always_comb begin
        state_d   = state_q;
        xs0_d     = xs0_q;
        xs1_d     = xs1_q;
        fresh_d   = fresh_q;
        out_d     = out_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        sbox_rst  = 1'b0;
        err       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // The only point where plain data meets a share; result is registered
                    xs0_d   = in_data ^ w_rand[3:0];
                    xs1_d   = w_rand[3:0];
                    fresh_d = w_rand[7:4];
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                sbox_rst = 1'b1;
                cnt_d    = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (Synch) begin
                    state_d = ST_CAPTURE;
                end else if (cnt_q == c_CNT_W'(TIMEOUT - 1)) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                out_d   = Y_s0 ^ Y_s1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            xs0_q   <= '0;
            xs1_q   <= '0;
            fresh_q <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            xs0_q   <= xs0_d;
            xs1_q   <= xs1_d;
            fresh_q <= fresh_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign X_s0     = xs0_q;
    assign X_s1     = xs1_q;
    assign Fresh    = fresh_q;
    assign out_data = out_q;

endmodule
`default_nettype wire

// File: doc/sbox_share_sequencer.md
SBOX_SHARE_SEQUENCER -- requirements
Module: sbox_share_sequencer

Interface
REQ-001 SHALL have parameter LATENCY, default 5: gated-clock period programmed into the downstream masked S-box's clock-gating controller.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum number of WAIT cycles before the error path is taken.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_data (input, 4): unmasked input nibble, valid/ready handshake.
REQ-006 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, 4): recombined S-box result.
REQ-007 SHALL have ports seed_load (input, 1) and seed_val (input, 16): LFSR seed load.
REQ-008 SHALL have ports X_s0 and X_s1 (output, 4 each): input shares driven to the masked S-box.
REQ-009 SHALL have port Fresh, output, 4 bits: fresh randomness driven to the S-box multipliers.
REQ-010 SHALL have port sbox_rst, output, 1 bit: active-high restart for the S-box clock-gating controller.
REQ-011 SHALL have ports Synch (input, 1), Y_s0 and Y_s1 (input, 4 each): completion flag and output shares from the S-box.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse on timeout.

Function
REQ-013 SHALL implement FSM states IDLE, ARM, WAIT, CAPTURE, OUT.
REQ-014 in_ready SHALL be high only in IDLE; an accept is in_valid&&in_ready.
REQ-015 On accept: SHALL register mask m=lfsr[3:0], X_s0=in_data^m, X_s1=m, Fresh=lfsr[7:4], then go to ARM.
REQ-016 X_s0, X_s1 and Fresh SHALL hold stable from accept until the FSM returns to IDLE.
REQ-017 ARM SHALL last exactly one cycle with sbox_rst=1, then go to WAIT; sbox_rst SHALL be 0 in every other state.
REQ-018 WAIT SHALL run a cycle counter from 0; Synch=1 moves to CAPTURE.
REQ-019 WAIT with counter==TIMEOUT-1 and Synch=0 SHALL pulse err for one cycle and return to IDLE.
REQ-020 If Synch and the timeout coincide, Synch SHALL win: no err, go to CAPTURE.
REQ-021 CAPTURE SHALL sample Y_s0^Y_s1 into out_data (this is one cycle after Synch, when the S-box output registers have updated), then go to OUT.
REQ-022 OUT SHALL hold out_valid=1 with out_data stable until out_ready=1, then go to IDLE.
REQ-023 Synch SHALL be ignored outside WAIT.
REQ-024 Unmasked data (in_data, out_data) SHALL never be combined with shares in a single combinational path driving X_s0/X_s1 other than the registered XOR in REQ-015.
REQ-025 LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, SHALL advance one step every cycle.
REQ-026 seed_load=1 SHALL overwrite the LFSR with seed_val that cycle; a zero seed SHALL load 16'hACE1 instead.
REQ-027 seed_load SHALL be honoured in any state; it SHALL not alter shares already latched.

Reset
REQ-028 On rst=0 asynchronously: FSM=IDLE; X_s0, X_s1, Fresh, out_data, the counter=0; out_valid=err=sbox_rst=0; LFSR=16'hACE1.
REQ-029 Reset mid-operation SHALL abandon the transaction with no out_valid or err after release; in_ready SHALL be 1 on the first cycle after release.

Structure
REQ-030 A shared package SHALL hold the FSM state enum, LFSR width, tap mask, the default seed 16'hACE1, and the share width of 4.
REQ-031 The LFSR SHALL be a sub-module named sbox_fresh_lfsr; everything else SHALL be flat.

Verification
REQ-032 Behavioural S-box model asserts Synch 5 cycles after sbox_rst falls. Driving in_data=4'h0..4'hF back-to-back with out_ready=1 SHALL give out_data equal to the Skinny-64 S-box (4'h0 yields 4'hC) for each input.
REQ-033 Seed 16'h0001 then input 4'h5 SHALL give X_s0^X_s1=4'h5, with X_s1 and Fresh equal to the golden-LFSR bits at the accept cycle.
REQ-034 Model that never asserts Synch SHALL produce an err pulse exactly 16 WAIT cycles after ARM, followed by in_ready=1.
REQ-035 Holding out_ready=0 for 10 cycles SHALL keep out_valid=1 with out_data stable, and in_ready=0 throughout.
REQ-036 rst=0 asserted during WAIT SHALL give all outputs zero immediately, no err, and in_ready=1 after release.
REQ-037 seed_load with seed_val=0 SHALL make the LFSR read 16'hACE1 on the next cycle.
